spi_controller_single_clk: RTL and testbench
============================================

# spi_controller_single_clk

SPI mode-0 controller (initiator) running entirely in the `sys_clk` domain. It generates SCK, CSn and MOSI, and samples MISO. Each transaction sends one address byte followed by 0–63 data bytes, MSB first, and returns every byte clocked back from the peripheral. It is the board-side counterpart used to exercise and drive the `spi_single_clk` peripheral from a second iCE40 design or a test harness.

## Interface
- `BYTE_W`, 8, bits per byte.
- `CLK_DIV`, 4, `sys_clk` cycles per SCK half-period. Legal range is 2–255. Use ≥4 against `spi_single_clk`, which oversamples SCK.
- `sys_clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle request; sampled only when `busy`=0.
- `tx_address` in BYTE_W: address byte, captured on the `start` cycle.
- `byte_count` in 6: number of data bytes after the address (0–63), captured on the `start` cycle.
- `tx_data` in BYTE_W: next data byte, first-word-fall-through; sampled on the `tx_dreq` cycle.
- `tx_dreq` out 1: one-cycle pulse; `tx_data` consumed this cycle and the caller advances.
- `rx_data` out BYTE_W: last byte received.
- `rx_valid` out 1: one-cycle pulse; `rx_data`/`rx_index` are new this cycle.
- `rx_index` out 6: byte index of `rx_data` (0 = byte clocked during the address).
- `busy` out 1: transaction in progress.
- `done` out 1: one-cycle pulse on the CSn deassert cycle.
- `csn_pad` out 1, `sck_pad` out 1, `mosi_pad` out 1, `miso_pad` in 1.

## Operation
- All outputs are registered.
- Reset values: `csn_pad`=1, `sck_pad`=0, `mosi_pad`=0, `busy`=0, `done`=0, `tx_dreq`=0, `rx_valid`=0, `rx_data`=0, `rx_index`=0.
- States:
  - IDLE→SETUP on `start`.
  - SETUP (CSn low, SCK low, CLK_DIV cycles)→SHIFT.
  - SHIFT (8·N bits, N=`byte_count`+1)→HOLD after the last SCK fall.
  - HOLD (CLK_DIV cycles)→GAP, raising CSn and pulsing `done`.
  - GAP (CLK_DIV cycles, CSn high)→IDLE, where `busy` falls.
- A half-period counter counts 0..CLK_DIV-1; SCK toggles on wrap. A bit counter counts 0–7 and a byte counter counts 0..`byte_count`, with no wrap beyond `byte_count`.
- MOSI:
  - Bit 7 of `tx_address` is driven on the SETUP entry cycle.
  - Each subsequent bit updates on the cycle SCK falls.
  - The next byte loads from `tx_data` on the 8th falling edge of the previous byte; `tx_dreq` pulses on that cycle.
  - No `tx_dreq` occurs when `byte_count`=0.
- MISO:
  - Passes through a 2-flop synchronizer.
  - The synchronized bit shifts in (MSB first) on the cycle SCK falls, i.e. at the end of the high phase. This covers peripheral and synchronizer latency.
  - On the 8th capture of a byte: `rx_data` updates, `rx_index` = byte index, and `rx_valid` pulses on the same cycle.
- `start` while `busy`=1 is ignored; no capture and no effect.
- `start` on the same cycle `busy` falls is ignored. `start` one cycle later is accepted.
- `tx_address`/`byte_count` changes after the `start` cycle have no effect.
- `rst` mid-transaction: all outputs take reset values immediately (asynchronously). CSn rises without a trailing SCK edge. The partial byte is discarded; no `rx_valid`, no `done`.
- `done` never coincides with `rx_valid`. The last `rx_valid` comes CLK_DIV cycles earlier.

## Timing
- Cycle 0: `start` high in IDLE.
- Cycle 1: `busy`=1, `csn_pad`=0, `mosi_pad`=address bit 7.
- Rising SCK edge k (k=0..8N-1) occurs at cycle 1+(2k+1)·CLK_DIV. The matching fall occurs at 1+(2k+2)·CLK_DIV.
- Last fall is at cycle 1+16N·CLK_DIV.
- `csn_pad`=1 and `done` are at cycle 1+(16N+1)·CLK_DIV.
- `busy`=0 is at cycle 1+(16N+2)·CLK_DIV.
- Examples:
  - CLK_DIV=4, N=1: CSn rises at 69, `busy` falls at 73.
  - CLK_DIV=4, N=4: CSn rises at 261, `busy` falls at 265.
- Byte j's `rx_valid` and byte j+1's `tx_dreq` fire on the cycle 1+16(j+1)·CLK_DIV.
- SCK period is 2·CLK_DIV cycles, 50% duty. With a 24 MHz `sys_clk` and CLK_DIV=4, SCK is 3 MHz.

## Test plan
- Reset value check: assert `rst` for 3 cycles. Required: all outputs at their reset values; `csn_pad`=1, `sck_pad`=0 held while idle.
- Address-only transfer: `start`, address 0xAA, `byte_count`=0, MISO model returns 0x3C. Required:
  - MOSI shows 10101010 across 8 rising edges.
  - One `rx_valid` with `rx_data`=0x3C and `rx_index`=0; no `tx_dreq`.
  - CSn rises at cycle 69 and `busy` falls at cycle 73 (CLK_DIV=4).
- Multi-byte transfer: address 0x02, `byte_count`=3, FIFO 0x11/0x22/0x33, peripheral returns 0xFF/0x01/0x02/0x00. Required:
  - Exactly 3 `tx_dreq`.
  - MOSI bytes 0x02,0x11,0x22,0x33.
  - Four `rx_valid` with indices 0–3 and matching data.
  - `done` once at cycle 261.
- `start` held during `busy`: pulse `start` with different address 0x55 mid-SHIFT. Required: transaction unchanged; no second transaction launched.
- Reset mid-transaction: assert `rst` during byte 1 bit 4. Required: CSn=1 and SCK=0 immediately; no further `rx_valid`/`done`; a fresh `start` after release runs a full, correct transfer.
- CLK_DIV=2 back-to-back: two transactions started on the cycle after each `busy` falls. Required:
  - SCK half-period of 2 cycles.
  - CSn high for exactly CLK_DIV cycles plus 2 between transactions.
  - Both transactions correct.

Source files
------------

// File: rtl/spi_controller_single_clk_if.sv
// spi_controller_single_clk_if
// Host-side handshake bundle for the SPI mode-0 controller.
//   start/tx_address/byte_count : transaction request, captured on the start cycle
//   tx_data/tx_dreq             : first-word-fall-through data source and its pop strobe
//   rx_data/rx_valid/rx_index   : received byte, its strobe and its position in the frame
//   busy/done                   : transaction in progress / CSn-deassert pulse
// The master modport is the host; the slave modport is the controller.
interface spi_controller_single_clk_if #(
    parameter int BYTE_W = 8
);
    logic              start;
    logic [BYTE_W-1:0] tx_address;
    logic [5:0]        byte_count;
    logic [BYTE_W-1:0] tx_data;
    logic              tx_dreq;
    logic [BYTE_W-1:0] rx_data;
    logic              rx_valid;
    logic [5:0]        rx_index;
    logic              busy;
    logic              done;

    modport master (
        output start, tx_address, byte_count, tx_data,
        input  tx_dreq, rx_data, rx_valid, rx_index, busy, done
    );

    modport slave (
        input  start, tx_address, byte_count, tx_data,
        output tx_dreq, rx_data, rx_valid, rx_index, busy, done
    );
endinterface

// File: rtl/spi_controller_single_clk.sv
// spi_controller_single_clk
// SPI mode-0 initiator in a single sys_clk domain. Sends one address byte
// followed by 0..63 data bytes MSB first and returns every byte clocked back.
// Ports:
//   sys_clk  : sole clock, rising edge
//   rst      : asynchronous active-high reset
//   host     : handshake bundle (slave modport)
//   csn_pad  : chip select, active low
//   sck_pad  : serial clock, idle low
//   mosi_pad : serial data out
//   miso_pad : serial data in (asynchronous to sys_clk, synchronized here)
module spi_controller_single_clk #(
    parameter int BYTE_W  = 8,
    parameter int CLK_DIV = 4
) (
    input  logic                        sys_clk,
    input  logic                        rst,
    spi_controller_single_clk_if.slave  host,
    output logic                        csn_pad,
    output logic                        sck_pad,
    output logic                        mosi_pad,
    input  logic                        miso_pad
);
    localparam int               BIT_W    = $clog2(BYTE_W);
    localparam logic [7:0]       DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BYTE_W - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t            state;
    state_t            state_next;
    logic [7:0]        half_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [5:0]        byte_cnt;
    logic [5:0]        count_q;
    // mosi_pad holds the current MSB, so only the remaining bits are kept here
    logic [BYTE_W-2:0] tx_rest;
    // the 8th bit goes straight into rx_data, so the shifter is one bit short
    logic [BYTE_W-2:0] rx_shift;
    logic              miso_meta;
    logic              miso_sync;
    // high for the single cycle busy falls, so a start on that cycle is ignored
    logic              rearm;

    logic wrap;
    logic accept;
    logic fall;
    logic last_fall;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The half-period wrap paces every state; a fall is a wrap while SCK is high.
    always_comb begin
        wrap       = (half_cnt == DIV_LAST);
        accept     = (state == IDLE) && host.start && !rearm;
        fall       = (state == SHIFT) && wrap && sck_pad;
        last_fall  = fall && (bit_cnt == BIT_LAST) && (byte_cnt == count_q);
        state_next = state;
        case (state)
            IDLE:    if (accept)    state_next = SETUP;
            SETUP:   if (wrap)      state_next = SHIFT;
            SHIFT:   if (last_fall) state_next = HOLD;
            HOLD:    if (wrap)      state_next = GAP;
            GAP:     if (wrap)      state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Datapath and registered outputs. The SETUP wrap is the first SCK rise;
    // every fall shifts MISO in and the next MOSI bit out, and the 8th fall of
    // a byte completes the receive and pops the next transmit byte.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            half_cnt      <= '0;
            bit_cnt       <= '0;
            byte_cnt      <= '0;
            count_q       <= '0;
            tx_rest       <= '0;
            rx_shift      <= '0;
            miso_meta     <= 1'b0;
            miso_sync     <= 1'b0;
            rearm         <= 1'b0;
            csn_pad       <= 1'b1;
            sck_pad       <= 1'b0;
            mosi_pad      <= 1'b0;
            host.busy     <= 1'b0;
            host.done     <= 1'b0;
            host.tx_dreq  <= 1'b0;
            host.rx_valid <= 1'b0;
            host.rx_data  <= '0;
            host.rx_index <= '0;
        end else begin
            host.tx_dreq  <= 1'b0;
            host.rx_valid <= 1'b0;
            host.done     <= 1'b0;
            rearm         <= 1'b0;
            miso_meta     <= miso_pad;
            miso_sync     <= miso_meta;

            if (state == IDLE || wrap) begin
                half_cnt <= '0;
            end else begin
                half_cnt <= half_cnt + 8'd1;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        host.busy <= 1'b1;
                        csn_pad   <= 1'b0;
                        mosi_pad  <= host.tx_address[BYTE_W-1];
                        tx_rest   <= host.tx_address[BYTE_W-2:0];
                        count_q   <= host.byte_count;
                        bit_cnt   <= '0;
                        byte_cnt  <= '0;
                    end
                end
                SETUP: begin
                    if (wrap) sck_pad <= 1'b1;
                end
                SHIFT: begin
                    if (wrap) sck_pad <= !sck_pad;
                    if (fall) begin
                        rx_shift <= {rx_shift[BYTE_W-3:0], miso_sync};
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt       <= '0;
                            host.rx_data  <= {rx_shift, miso_sync};
                            host.rx_index <= byte_cnt;
                            host.rx_valid <= 1'b1;
                            if (byte_cnt != count_q) begin
                                byte_cnt     <= byte_cnt + 6'd1;
                                mosi_pad     <= host.tx_data[BYTE_W-1];
                                tx_rest      <= host.tx_data[BYTE_W-2:0];
                                host.tx_dreq <= 1'b1;
                            end else begin
                                mosi_pad <= 1'b0;
                            end
                        end else begin
                            bit_cnt  <= bit_cnt + BIT_W'(1);
                            mosi_pad <= tx_rest[BYTE_W-2];
                            tx_rest  <= {tx_rest[BYTE_W-3:0], 1'b0};
                        end
                    end
                end
                HOLD: begin
                    if (wrap) begin
                        csn_pad   <= 1'b1;
                        host.done <= 1'b1;
                    end
                end
                GAP: begin
                    if (wrap) begin
                        host.busy <= 1'b0;
                        rearm     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_controller_single_clk.sv
// tb_spi_controller_single_clk
// Bench for spi_controller_single_clk: one instance with CLK_DIV=4 and one
// with CLK_DIV=2 share clock, reset and a behavioural mode-0 peripheral that
// presents bits while CSn is low and advances on every SCK fall.
module tb_spi_controller_single_clk;
    typedef struct packed {
        bit              div2;
        logic [7:0]      addr;
        logic [5:0]      cnt;
        logic [3:0][7:0] tx;
        logic [4:0][7:0] miso;
        int              csn_rise;
        int              busy_fall;
    } vec_t;

    logic       sys_clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] tx_address = 8'h00;
    logic [5:0] byte_count = 6'd0;
    logic [7:0] tx_data = 8'h00;
    logic       miso = 1'b0;
    logic       sel = 1'b0;

    always #5 sys_clk = ~sys_clk;

    spi_controller_single_clk_if #(.BYTE_W(8)) bus4 ();
    spi_controller_single_clk_if #(.BYTE_W(8)) bus2 ();
    logic csn4, sck4, mosi4, csn2, sck2, mosi2;

    assign bus4.start      = start & ~sel;
    assign bus4.tx_address = tx_address;
    assign bus4.byte_count = byte_count;
    assign bus4.tx_data    = tx_data;
    assign bus2.start      = start & sel;
    assign bus2.tx_address = tx_address;
    assign bus2.byte_count = byte_count;
    assign bus2.tx_data    = tx_data;

    spi_controller_single_clk #(.BYTE_W(8), .CLK_DIV(4)) dut4 (
        .sys_clk (sys_clk), .rst (rst), .host (bus4),
        .csn_pad (csn4), .sck_pad (sck4), .mosi_pad (mosi4), .miso_pad (miso)
    );

    spi_controller_single_clk #(.BYTE_W(8), .CLK_DIV(2)) dut2 (
        .sys_clk (sys_clk), .rst (rst), .host (bus2),
        .csn_pad (csn2), .sck_pad (sck2), .mosi_pad (mosi2), .miso_pad (miso)
    );

    logic       m_csn, m_sck, m_mosi, m_busy, m_done, m_dreq, m_rxv;
    logic [7:0] m_rxd;
    logic [5:0] m_rxi;
    assign m_csn  = sel ? csn2 : csn4;
    assign m_sck  = sel ? sck2 : sck4;
    assign m_mosi = sel ? mosi2 : mosi4;
    assign m_busy = sel ? bus2.busy : bus4.busy;
    assign m_done = sel ? bus2.done : bus4.done;
    assign m_dreq = sel ? bus2.tx_dreq : bus4.tx_dreq;
    assign m_rxv  = sel ? bus2.rx_valid : bus4.rx_valid;
    assign m_rxd  = sel ? bus2.rx_data : bus4.rx_data;
    assign m_rxi  = sel ? bus2.rx_index : bus4.rx_index;

    int tests = 0;
    int failed = 0;
    int cyc = 0;
    int abs_cyc = 0;
    int cur_div = 4;
    logic prev_sck, prev_csn, prev_busy;
    int miso_idx, rise_bits, dreq_cnt, done_cnt, done_cyc;
    int csn_rise_cyc, busy_fall_cyc, last_toggle, bad_half, overlap;
    int csn_rise_abs, csn_fall_abs;
    logic [7:0] mosi_acc;
    logic [7:0] miso_bytes [64];
    logic [7:0] tx_bytes [64];
    logic [7:0] mosi_q [$];
    logic [7:0] rx_q [$];
    int rx_idx_q [$];
    int rx_cyc_q [$];
    int dreq_cyc_q [$];
    vec_t vecs [4];
    vec_t v_b2b;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clearMon();
        cyc = 0;
        miso_idx = 0; rise_bits = 0; dreq_cnt = 0; done_cnt = 0; done_cyc = -1;
        csn_rise_cyc = -1; busy_fall_cyc = -1; last_toggle = 0; bad_half = 0; overlap = 0;
        mosi_acc = 8'h00;
        mosi_q.delete(); rx_q.delete(); rx_idx_q.delete(); rx_cyc_q.delete(); dreq_cyc_q.delete();
        prev_sck = m_sck; prev_csn = m_csn; prev_busy = m_busy;
    endtask

    // Advance one cycle, sample 1 time unit after the edge, and update the
    // peripheral model and event logs.
    task automatic tick();
        @(posedge sys_clk);
        #1;
        cyc++;
        abs_cyc++;
        if (!m_csn && prev_csn) begin csn_fall_abs = abs_cyc; last_toggle = cyc; end
        if (m_csn && !prev_csn) begin csn_rise_abs = abs_cyc; csn_rise_cyc = cyc; end
        if (m_sck !== prev_sck) begin
            if (cyc - last_toggle != cur_div) bad_half++;
            last_toggle = cyc;
        end
        if (m_sck && !prev_sck) begin
            mosi_acc = {mosi_acc[6:0], m_mosi};
            rise_bits++;
            if (rise_bits % 8 == 0) mosi_q.push_back(mosi_acc);
        end
        if (!m_sck && prev_sck) miso_idx++;
        if (m_dreq) begin
            dreq_cnt++;
            dreq_cyc_q.push_back(cyc);
            tx_data = (dreq_cnt < 64) ? tx_bytes[dreq_cnt] : 8'h00;
        end
        if (m_rxv) begin
            rx_q.push_back(m_rxd);
            rx_idx_q.push_back(int'(m_rxi));
            rx_cyc_q.push_back(cyc);
        end
        if (m_done) begin
            done_cnt++;
            done_cyc = cyc;
            if (m_rxv) overlap++;
        end
        if (!m_busy && prev_busy) busy_fall_cyc = cyc;
        miso = (!m_csn && miso_idx < 512) ? miso_bytes[miso_idx / 8][7 - (miso_idx % 8)] : 1'b0;
        prev_sck = m_sck; prev_csn = m_csn; prev_busy = m_busy;
    endtask

    // Launch one transaction and run it until busy falls. poke_cyc injects a
    // foreign start mid-transfer; rst_cyc aborts it with an asynchronous reset.
    task automatic applyStimulus(input vec_t v, input bit immediate, input int poke_cyc, input int rst_cyc);
        if (!immediate) repeat (3) tick();
        sel = v.div2;
        cur_div = v.div2 ? 2 : 4;
        for (int i = 0; i < 64; i++) begin
            miso_bytes[i] = (i < 5) ? v.miso[i] : 8'h00;
            tx_bytes[i]   = (i < 4) ? v.tx[i] : 8'h00;
        end
        clearMon();
        tx_address = v.addr;
        byte_count = v.cnt;
        tx_data = tx_bytes[0];
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("first_cycle", 32'({m_busy, m_csn, m_mosi}), 32'({1'b1, 1'b0, v.addr[7]}));
        while (m_busy === 1'b1 && cyc < 3000) begin
            if (cyc == poke_cyc) begin
                start = 1'b1;
                tx_address = 8'h55;
                byte_count = 6'd5;
            end else if (cyc == poke_cyc + 1) begin
                start = 1'b0;
            end
            if (cyc == rst_cyc) begin
                rst = 1'b1;
                #1;
                checkOutput("rst_async_pads", 32'({m_csn, m_sck, m_busy, m_rxv, m_done}), 32'(5'b10000));
                tick();
                tick();
                rst = 1'b0;
            end else begin
                tick();
            end
        end
        start = 1'b0;
        checkOutput("busy_released", 32'(m_busy), 32'(0));
    endtask

    task automatic checkTxn(input vec_t v, input string tag);
        int n = int'(v.cnt) + 1;
        int d = v.div2 ? 2 : 4;
        checkOutput({tag, "_dreq_count"}, 32'(dreq_cnt), 32'(v.cnt));
        checkOutput({tag, "_rx_count"}, 32'(rx_q.size()), 32'(n));
        checkOutput({tag, "_mosi_count"}, 32'(mosi_q.size()), 32'(n));
        for (int j = 0; j < n; j++) begin
            logic [7:0] exp_mosi;
            int want_cyc;
            want_cyc = 1 + 16 * (j + 1) * d;
            if (j == 0) exp_mosi = v.addr;
            else        exp_mosi = v.tx[j-1];
            checkOutput($sformatf("%s_mosi%0d", tag, j),
                        (j < mosi_q.size()) ? 32'(mosi_q[j]) : 32'hFFFF_FFFF, 32'(exp_mosi));
            checkOutput($sformatf("%s_rxdata%0d", tag, j),
                        (j < rx_q.size()) ? 32'(rx_q[j]) : 32'hFFFF_FFFF, 32'(v.miso[j]));
            checkOutput($sformatf("%s_rxindex%0d", tag, j),
                        (j < rx_idx_q.size()) ? rx_idx_q[j] : -1, j);
            checkOutput($sformatf("%s_rxcycle%0d", tag, j),
                        (j < rx_cyc_q.size()) ? rx_cyc_q[j] : -1, want_cyc);
            if (j < n - 1) begin
                checkOutput($sformatf("%s_dreqcycle%0d", tag, j),
                            (j < dreq_cyc_q.size()) ? dreq_cyc_q[j] : -1, want_cyc);
            end
        end
        checkOutput({tag, "_done_count"}, 32'(done_cnt), 32'(1));
        checkOutput({tag, "_done_cycle"}, done_cyc, v.csn_rise);
        checkOutput({tag, "_csn_rise_cycle"}, csn_rise_cyc, v.csn_rise);
        checkOutput({tag, "_busy_fall_cycle"}, busy_fall_cyc, v.busy_fall);
        checkOutput({tag, "_sck_half_period"}, 32'(bad_half), 32'(0));
        checkOutput({tag, "_done_rx_overlap"}, 32'(overlap), 32'(0));
    endtask

    initial begin
        int   first_rise;
        logic idle_ok;

        vecs[0] = '0;
        vecs[0].addr = 8'hAA; vecs[0].cnt = 6'd0;
        vecs[0].miso[0] = 8'h3C;
        vecs[0].csn_rise = 69; vecs[0].busy_fall = 73;

        vecs[1] = '0;
        vecs[1].addr = 8'h02; vecs[1].cnt = 6'd3;
        vecs[1].tx[0] = 8'h11; vecs[1].tx[1] = 8'h22; vecs[1].tx[2] = 8'h33;
        vecs[1].miso[0] = 8'hFF; vecs[1].miso[1] = 8'h01; vecs[1].miso[2] = 8'h02; vecs[1].miso[3] = 8'h00;
        vecs[1].csn_rise = 261; vecs[1].busy_fall = 265;

        vecs[2] = '0;
        vecs[2].addr = 8'hC3; vecs[2].cnt = 6'd1;
        vecs[2].tx[0] = 8'h5A;
        vecs[2].miso[0] = 8'h81; vecs[2].miso[1] = 8'h7E;
        vecs[2].csn_rise = 133; vecs[2].busy_fall = 137;

        vecs[3] = '0;
        vecs[3].div2 = 1'b1;
        vecs[3].addr = 8'h96; vecs[3].cnt = 6'd2;
        vecs[3].tx[0] = 8'h0F; vecs[3].tx[1] = 8'hF0;
        vecs[3].miso[0] = 8'hA5; vecs[3].miso[1] = 8'h5A; vecs[3].miso[2] = 8'hC3;
        vecs[3].csn_rise = 99; vecs[3].busy_fall = 101;

        clearMon();
        repeat (3) tick();
        checkOutput("reset_dut4", 32'({csn4, sck4, mosi4, bus4.busy, bus4.done, bus4.tx_dreq,
                                       bus4.rx_valid, bus4.rx_data, bus4.rx_index}),
                    32'({1'b1, 6'b000000, 8'h00, 6'd0}));
        checkOutput("reset_dut2", 32'({csn2, sck2, mosi2, bus2.busy, bus2.done, bus2.tx_dreq,
                                       bus2.rx_valid, bus2.rx_data, bus2.rx_index}),
                    32'({1'b1, 6'b000000, 8'h00, 6'd0}));
        rst = 1'b0;
        repeat (5) tick();
        checkOutput("idle_pads", 32'({csn4, sck4, csn2, sck2}), 32'(4'b1010));

        for (int i = 0; i < 4; i++) begin
            applyStimulus(vecs[i], 1'b0, -1, -1);
            checkTxn(vecs[i], $sformatf("vec%0d", i));
        end

        // Foreign start mid-SHIFT, then a start on the very cycle busy falls.
        applyStimulus(vecs[0], 1'b0, 30, -1);
        checkTxn(vecs[0], "poke");
        start = 1'b1;
        tx_address = 8'h55;
        tick();
        start = 1'b0;
        idle_ok = 1'b1;
        repeat (20) begin
            tick();
            if (m_busy !== 1'b0 || m_csn !== 1'b1) idle_ok = 1'b0;
        end
        checkOutput("no_relaunch", 32'(idle_ok), 32'(1));

        // Reset while byte 1 bit 4 is in its high phase.
        applyStimulus(vecs[1], 1'b0, -1, 103);
        repeat (300) tick();
        checkOutput("rst_rx_count", 32'(rx_q.size()), 32'(1));
        checkOutput("rst_no_done", 32'(done_cnt), 32'(0));
        applyStimulus(vecs[1], 1'b0, -1, -1);
        checkTxn(vecs[1], "after_rst");

        // CLK_DIV=2 back-to-back, second start one cycle after busy falls.
        applyStimulus(vecs[3], 1'b0, -1, -1);
        checkTxn(vecs[3], "b2b_first");
        first_rise = csn_rise_abs;
        tick();
        v_b2b = vecs[3];
        v_b2b.addr = 8'h3C;
        v_b2b.tx[0] = 8'h81; v_b2b.tx[1] = 8'h7E;
        v_b2b.miso[0] = 8'h00; v_b2b.miso[1] = 8'hFF; v_b2b.miso[2] = 8'h69;
        applyStimulus(v_b2b, 1'b1, -1, -1);
        checkTxn(v_b2b, "b2b_second");
        checkOutput("b2b_csn_high", 32'(csn_fall_abs - first_rise), 32'(4));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
